// File: rtl/ram_pkg.sv
// Shared definitions for the ram_bank data RAM: FSM encoding, lane width and byte parity helper.
package ram_pkg;

   localparam int LANE_W = 8;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_e;

   // Even parity: stored bit makes the total count of ones in lane+parity even.
   function automatic logic byte_parity(input logic [LANE_W-1:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Post-reset clear sequencer: walks every word address once, writing zero, then parks in IDLE.
module ram_clear_ctrl
   import ram_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   output logic              clr_we_o,
   output logic [ADDR_W-1:0] clr_addr_o,
   output logic              busy_o
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The counter wraps back to 0 on the last clear write, ready for the next reset.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clr_we_o = 1'b0;
      busy_o   = 1'b0;
      unique case (state_q)
         ST_CLEAR: begin
            clr_we_o = 1'b1;
            busy_o   = 1'b1;
            cnt_d    = cnt_q + ADDR_W'(1);
            if (&cnt_q) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   assign clr_addr_o = cnt_q;

endmodule

// File: rtl/ram_bank.sv
// Single-port data RAM with byte-lane writes, registered read + valid strobe and post-reset clear.
// Optional per-lane even parity storage and checking when RAM_PARITY_EN is defined.
module ram_bank
   import ram_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BYTES  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ram_ena,
   input  logic              wena,
   input  logic [BYTES-1:0]  byte_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              busy,
   output logic              parity_err
);

   localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
   localparam int MEM_W = DATA_W + BYTES;
`else
   localparam int MEM_W = DATA_W;
`endif

   logic [MEM_W-1:0]  mem [DEPTH];

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              wr_en, rd_en;
   logic [MEM_W-1:0]  rd_word;
   logic              rd_perr;

   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              rd_valid_q, rd_valid_d;
   logic              parity_err_q, parity_err_d;

   ram_clear_ctrl #(
      .ADDR_W (ADDR_W)
   ) u_clear (
      .clk        (clk),
      .rst        (rst),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr),
      .busy_o     (busy)
   );

   assign wr_en   = ram_ena & wena & ~busy;
   assign rd_en   = ram_ena & ~wena & ~busy;
   assign rd_word = mem[addr];

   // Clear writes take the port; user accesses are dropped while busy.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < BYTES; i++) begin
            if (byte_en[i]) begin
               mem[addr][i*LANE_W +: LANE_W] <= data_in[i*LANE_W +: LANE_W];
`ifdef RAM_PARITY_EN
               mem[addr][DATA_W+i] <= byte_parity(data_in[i*LANE_W +: LANE_W]);
`endif
            end
         end
      end
   end

`ifdef RAM_PARITY_EN
   always_comb begin
      rd_perr = 1'b0;
      for (int i = 0; i < BYTES; i++) begin
         if (byte_parity(rd_word[i*LANE_W +: LANE_W]) != rd_word[DATA_W+i]) begin
            rd_perr = 1'b1;
         end
      end
   end
`else
   assign rd_perr = 1'b0;
`endif

   always_comb begin
      data_out_d   = data_out_q;
      rd_valid_d   = 1'b0;
      parity_err_d = 1'b0;
      if (rd_en) begin
         data_out_d   = rd_word[DATA_W-1:0];
         rd_valid_d   = 1'b1;
         parity_err_d = rd_perr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out_q   <= '0;
         rd_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         data_out_q   <= data_out_d;
         rd_valid_q   <= rd_valid_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign data_out   = data_out_q;
   assign rd_valid   = rd_valid_q;
   assign parity_err = parity_err_q;

endmodule
